// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer with jump/branch redirect, stall and halt
//
// Purpose: walks a program counter through a combinational program memory,
// registering each fetched word into ir. Redirects flush one wrong-path fetch.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   start        begin execution at address 0 from IDLE or HALT
//   stall        freeze all state for the cycle
//   halt         stop after the instruction held in ir
//   jump         absolute redirect to jump_addr
//   jump_addr    absolute target
//   branch       relative redirect to ir_addr + branch_off
//   branch_off   two's-complement offset
//   instruction  program-memory read data for address
//   address      program counter to program memory
//   ir           current instruction
//   ir_addr      address ir was fetched from
//   ir_valid     ir holds a valid, non-flushed instruction
//   running      high in FETCH or RUN
//   halted       high in HALT
module fetch_sequencer #(
    parameter int P_SIZE = 6,
    parameter int I_SIZE = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              halt,
    input  logic              jump,
    input  logic [P_SIZE-1:0] jump_addr,
    input  logic              branch,
    input  logic [P_SIZE-1:0] branch_off,
    input  logic [I_SIZE-1:0] instruction,
    output logic [P_SIZE-1:0] address,
    output logic [I_SIZE-1:0] ir,
    output logic [P_SIZE-1:0] ir_addr,
    output logic              ir_valid,
    output logic              running,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_RUN   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [P_SIZE-1:0] address_q, address_d;
    logic [I_SIZE-1:0] ir_q, ir_d;
    logic [P_SIZE-1:0] ir_addr_q, ir_addr_d;
    logic              ir_valid_q, ir_valid_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            address_q  <= '0;
            ir_q       <= '0;
            ir_addr_q  <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            address_q  <= address_d;
            ir_q       <= ir_d;
            ir_addr_q  <= ir_addr_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        address_d  = address_q;
        ir_d       = ir_q;
        ir_addr_d  = ir_addr_q;
        ir_valid_d = ir_valid_q;

        // Stall freezes everything, including control requests, in every state.
        if (!stall) begin
            unique case (state_q)
                S_IDLE: begin
                    address_d  = '0;
                    ir_valid_d = 1'b0;
                    if (start) begin
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir_d       = instruction;
                    ir_addr_d  = address_q;
                    address_d  = address_q + P_SIZE'(1);
                    ir_valid_d = 1'b1;
                    state_d    = S_RUN;
                end
                S_RUN: begin
                    // Control requests only act on a real instruction; during a
                    // bubble the target fetch proceeds sequentially.
                    if (halt && ir_valid_q) begin
                        state_d    = S_HALT;
                        ir_valid_d = 1'b0;
                    end else if (jump && ir_valid_q) begin
                        address_d  = jump_addr;
                        ir_valid_d = 1'b0;
                    end else if (branch && ir_valid_q) begin
                        address_d  = ir_addr_q + branch_off;
                        ir_valid_d = 1'b0;
                    end else begin
                        ir_d       = instruction;
                        ir_addr_d  = address_q;
                        address_d  = address_q + P_SIZE'(1);
                        ir_valid_d = 1'b1;
                    end
                end
                S_HALT: begin
                    ir_valid_d = 1'b0;
                    if (start) begin
                        address_d = '0;
                        state_d   = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign address  = address_q;
    assign ir       = ir_q;
    assign ir_addr  = ir_addr_q;
    assign ir_valid = ir_valid_q;
    assign running  = (state_q == S_FETCH) || (state_q == S_RUN);
    assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam int P_SIZE = 6;
    localparam int I_SIZE = 24;

    logic              clk;
    logic              reset;
    logic              start;
    logic              stall;
    logic              halt;
    logic              jump;
    logic [P_SIZE-1:0] jump_addr;
    logic              branch;
    logic [P_SIZE-1:0] branch_off;
    logic [I_SIZE-1:0] instruction;
    logic [P_SIZE-1:0] address;
    logic [I_SIZE-1:0] ir;
    logic [P_SIZE-1:0] ir_addr;
    logic              ir_valid;
    logic              running;
    logic              halted;

    int n_cmp;
    int n_bad;

    fetch_sequencer #(.P_SIZE(P_SIZE), .I_SIZE(I_SIZE)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stall      (stall),
        .halt       (halt),
        .jump       (jump),
        .jump_addr  (jump_addr),
        .branch     (branch),
        .branch_off (branch_off),
        .instruction(instruction),
        .address    (address),
        .ir         (ir),
        .ir_addr    (ir_addr),
        .ir_valid   (ir_valid),
        .running    (running),
        .halted     (halted)
    );

    // Program memory: mem[i] = i*3.
    assign instruction = I_SIZE'(address) * I_SIZE'(3);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},     32'(address), 32'd0);
        check({tag, "_ir"},       32'(ir), 32'd0);
        check({tag, "_ir_addr"},  32'(ir_addr), 32'd0);
        check({tag, "_ir_valid"}, 32'(ir_valid), 32'd0);
        check({tag, "_running"},  32'(running), 32'd0);
        check({tag, "_halted"},   32'(halted), 32'd0);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        start      = 1'b0;
        stall      = 1'b0;
        halt       = 1'b0;
        jump       = 1'b0;
        jump_addr  = '0;
        branch     = 1'b0;
        branch_off = '0;

        #1;
        check_reset_outputs("rst");
        step();
        step();
        reset = 1'b0;
        step();
        check("idle_no_start_running", 32'(running), 32'd0);
        check("idle_addr", 32'(address), 32'd0);

        // Cold start: two edges to first valid instruction.
        start = 1'b1;
        step();
        start = 1'b0;
        check("fetch_running", 32'(running), 32'd1);
        check("fetch_valid", 32'(ir_valid), 32'd0);
        step();
        check("cold_ir", 32'(ir), 32'h000000);
        check("cold_ir_addr", 32'(ir_addr), 32'd0);
        check("cold_addr", 32'(address), 32'd1);
        check("cold_valid", 32'(ir_valid), 32'd1);
        step();
        check("cold_ir2", 32'(ir), 32'h000003);
        check("cold_ir_addr2", 32'(ir_addr), 32'd1);

        // Branch at ir_addr=1 with offset 0x3E -> 63, then wrap to 0.
        branch     = 1'b1;
        branch_off = 6'h3E;
        step();
        branch = 1'b0;
        check("br_bubble_valid", 32'(ir_valid), 32'd0);
        check("br_addr", 32'(address), 32'd63);
        check("br_ir_addr_held", 32'(ir_addr), 32'd1);
        step();
        check("br_tgt_ir_addr", 32'(ir_addr), 32'd63);
        check("br_tgt_ir", 32'(ir), 32'd189);
        check("wrap_addr", 32'(address), 32'd0);
        check("br_tgt_valid", 32'(ir_valid), 32'd1);
        step();
        check("wrap_ir_addr", 32'(ir_addr), 32'd0);
        check("wrap_ir", 32'(ir), 32'd0);
        check("wrap_valid", 32'(ir_valid), 32'd1);

        // Advance to ir_addr=5, then jump and branch together: jump wins.
        for (int i = 0; i < 5; i++) step();
        check("seq_ir_addr5", 32'(ir_addr), 32'd5);
        jump       = 1'b1;
        jump_addr  = 6'd40;
        branch     = 1'b1;
        branch_off = 6'h3E;
        step();
        jump   = 1'b0;
        branch = 1'b0;
        check("jmp_bubble_valid", 32'(ir_valid), 32'd0);
        check("jmp_addr", 32'(address), 32'd40);
        check("jmp_ir_held", 32'(ir), 32'd15);
        step();
        check("jmp_ir_addr", 32'(ir_addr), 32'd40);
        check("jmp_ir", 32'(ir), 32'd120);
        check("jmp_valid", 32'(ir_valid), 32'd1);

        // Stall for 3 cycles with jump asserted: nothing moves.
        stall     = 1'b1;
        jump      = 1'b1;
        jump_addr = 6'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr", 32'(address), 32'd41);
            check("stall_ir", 32'(ir), 32'd120);
            check("stall_valid", 32'(ir_valid), 32'd1);
        end
        stall = 1'b0;
        jump  = 1'b0;
        step();
        check("post_stall_ir_addr", 32'(ir_addr), 32'd41);
        check("post_stall_ir", 32'(ir), 32'd123);

        // Reach ir_addr=10 via jump, then halt.
        jump      = 1'b1;
        jump_addr = 6'd10;
        step();
        jump = 1'b0;
        step();
        check("pre_halt_ir_addr", 32'(ir_addr), 32'd10);
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_valid", 32'(ir_valid), 32'd0);
        check("halt_addr", 32'(address), 32'd11);
        check("halt_running", 32'(running), 32'd0);
        step();
        check("halt_hold_addr", 32'(address), 32'd11);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_running", 32'(running), 32'd1);
        check("restart_halted", 32'(halted), 32'd0);
        check("restart_addr", 32'(address), 32'd0);
        step();
        check("restart_ir_addr", 32'(ir_addr), 32'd0);
        check("restart_valid", 32'(ir_valid), 32'd1);

        // start is ignored while running.
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ignored_ir_addr", 32'(ir_addr), 32'd1);
        check("start_ignored_addr", 32'(address), 32'd2);

        // Asynchronous reset between edges.
        #3;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        #2;
        reset = 1'b0;
        step();
        step();
        check("post_rst_running", 32'(running), 32'd0);
        check("post_rst_valid", 32'(ir_valid), 32'd0);
        check("post_rst_addr", 32'(address), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
